uart_rx_deframer: RTL

- Standalone UART receiver: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity by default.
- Pairs with the existing transmitter path. Its Rx_in is driven by the serial line (e.g. loopback of Tx_out), and it produces the byte on Rx_out.
- Runs on the 125 MHz system clock (cp = 8 ns) at 115200 baud.
- Uses mid-bit sampling driven by a clocks-per-bit counter.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_deframer_if.sv | 26 ++
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx_deframer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, frame geometry and line idle level.
// The PARITY state is only reached when the design is built with UART_RX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int   DEFAULT_CLKS_PER_BIT = 1085;
    localparam int   DATA_BITS            = 8;
    localparam logic LINE_IDLE            = 1'b1;

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Receive-side signal bundle between the serial line owner (master) and the deframer (slave).
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_deframer_if;
    import uart_pkg::*;

    logic                 Rx_ena;
    logic                 Rx_in;
    logic [DATA_BITS-1:0] Rx_out;
    logic                 Rx_valid;
    logic                 Rx_busy;
    logic                 frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (output Rx_ena, Rx_in,
                    input  Rx_out, Rx_valid, Rx_busy, frame_err, parity_err);
    modport slave  (input  Rx_ena, Rx_in,
                    output Rx_out, Rx_valid, Rx_busy, frame_err, parity_err);
`else
    modport master (output Rx_ena, Rx_in,
                    input  Rx_out, Rx_valid, Rx_busy, frame_err);
    modport slave  (input  Rx_ena, Rx_in,
                    output Rx_out, Rx_valid, Rx_busy, frame_err);
`endif

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset to RESET_VAL.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver: 8N1 mid-bit sampling deframer with framing-error detection and break hold-off.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop, reported on parity_err.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input logic              clk,
    input logic              rst,
    uart_rx_deframer_if.slave rx
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t            state, state_next;
    logic [15:0]          cnt, cnt_next;
    logic [2:0]           bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [DATA_BITS-1:0] out_reg, out_next;
    logic                 valid_reg, valid_next;
    logic                 ferr_reg, ferr_next;
    logic                 line;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_bad_next;
    logic                 perr_reg, perr_next;
`endif

    uart_sync2 #(.RESET_VAL(LINE_IDLE)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx.Rx_in),
        .q   (line)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            out_reg   <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
            perr_reg  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_idx_next;
            shift     <= shift_next;
            out_reg   <= out_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_bad   <= par_bad_next;
            perr_reg  <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        out_next     = out_reg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad;
        perr_next    = 1'b0;
`endif

        // Dropping the enable abandons any partial frame without reporting it.
        if (!rx.Rx_ena) begin
            state_next   = IDLE;
            cnt_next     = '0;
            bit_idx_next = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (line != LINE_IDLE) begin
                        state_next = START;
                        cnt_next   = '0;
                    end
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt_next     = '0;
                        bit_idx_next = '0;
                        state_next   = (line == LINE_IDLE) ? IDLE : DATA;
                    end else begin
                        cnt_next = cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt_next            = '0;
                        shift_next[bit_idx] = line;
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            bit_idx_next = bit_idx + 3'd1;
                        end
                    end else begin
                        cnt_next = cnt + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == LAST_CNT) begin
                        cnt_next     = '0;
                        par_bad_next = (^shift) ^ line;
                        state_next   = STOP;
                    end else begin
                        cnt_next = cnt + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt_next = '0;
                        if (line == LINE_IDLE) begin
                            out_next   = shift;
                            valid_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_next  = par_bad;
`endif
                            state_next = IDLE;
                        end else begin
                            ferr_next  = 1'b1;
                            state_next = BREAK;
                        end
                    end else begin
                        cnt_next = cnt + 16'd1;
                    end
                end
                // A line held low after a bad stop must not look like a fresh start bit.
                BREAK: begin
                    if (line == LINE_IDLE) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign rx.Rx_out    = out_reg;
    assign rx.Rx_valid  = valid_reg;
    assign rx.Rx_busy   = (state != IDLE);
    assign rx.frame_err = ferr_reg;
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = perr_reg;
`endif

endmodule
